// File: rtl/gate_alu_pipe.sv
// gate_alu_pipe: registered WIDTH-bit gate ALU with valid/ready output stage, accumulator and beat counter
module gate_alu_pipe #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [WIDTH-1:0] acc_q,
  output logic [CNT_W-1:0] txn_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic in_fire, out_fire;
  logic [WIDTH-1:0] acc_base, b_eff, result;
  assign out_valid = (state == FULL);
  assign in_ready = !out_valid | out_ready;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // a clear in the same cycle as an acc beat is seen by that beat
  assign acc_base = acc_clr ? ACC_INIT : acc_q;
  assign b_eff = acc ? acc_base : b;
  always_comb begin
    result = op == 3'd0 ? a & b_eff :
             op == 3'd1 ? a | b_eff :
             op == 3'd2 ? ~a :
             op == 3'd3 ? ~(a & b_eff) :
             op == 3'd4 ? ~(a | b_eff) :
             op == 3'd5 ? a :
             op == 3'd6 ? a ^ b_eff :
                          ~(a ^ b_eff);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      y <= '0;
      zero <= 1'b1;
      acc_q <= ACC_INIT;
      txn_cnt <= '0;
    end else begin
      if (in_fire) begin
        state <= FULL;
        y <= result;
        zero <= (result == '0);
      end else if (out_fire) begin
        state <= EMPTY;
      end
      if (in_fire & acc) acc_q <= result;
      else if (acc_clr) acc_q <= ACC_INIT;
      if (out_fire) txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_gate_alu_pipe.sv
// tb_gate_alu_pipe: randomized scoreboard bench for gate_alu_pipe (WIDTH=8, CNT_W=4)
module tb_gate_alu_pipe;
  localparam logic [7:0] INIT = 8'h00;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, acc = 0, acc_clr = 0, out_valid, out_ready = 1, zero;
  logic [2:0] op = 0;
  logic [7:0] a = 0, b = 0, y, acc_q;
  logic [3:0] txn_cnt;
  int checks = 0, failures = 0, mode = 0, mcnt = 0;
  logic [7:0] macc = INIT;
  logic [7:0] exp_q[$];

  gate_alu_pipe #(.WIDTH(8), .ACC_INIT(INIT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc(acc), .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .acc_q(acc_q), .txn_cnt(txn_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gate(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~x;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return x;
      3'd6: return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  initial forever begin
    @(posedge clk); #1;
    out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  // monitor: pops one expected result per consumed beat and tracks the counter
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("txn_cnt", txn_cnt, mcnt % 16);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", y, 32'hDEAD);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("y", y, e);
          chk("zero", zero, e == 0);
        end
        mcnt++;
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic ac, input logic cl);
    int n = 0;
    bit done = 0;
    op = o; a = aa; b = bb; acc = ac; acc_clr = cl; in_valid = 1;
    while (!done) begin
      @(negedge clk);
      chk("acc_q", acc_q, macc);
      if (in_ready) begin
        logic [7:0] base, r;
        base = cl ? INIT : macc;
        r = gate(o, aa, ac ? base : bb);
        exp_q.push_back(r);
        if (ac) macc = r;
        else if (cl) macc = INIT;
        done = 1;
      end else if (cl) macc = INIT;
      n++;
      if (!done && n > 50) begin
        chk("accept_timeout", 0, 1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 0; acc = 0; acc_clr = 0;
  endtask

  task automatic idle(input logic cl);
    in_valid = 0; acc_clr = cl;
    @(negedge clk);
    chk("acc_q", acc_q, macc);
    if (cl) macc = INIT;
    @(posedge clk); #1;
    acc_clr = 0;
  endtask

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 1);
    chk("rst_acc_q", acc_q, INIT);
    chk("rst_txn_cnt", txn_cnt, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(3'(i), 8'hF0, 8'hCC, 0, 0);
    idle(0);
    send(6, 8'h01, 8'h00, 1, 1);
    send(6, 8'h02, 8'h00, 1, 0);
    send(6, 8'h04, 8'h00, 1, 0);
    send(6, 8'h08, 8'h00, 1, 0);
    idle(0);
    chk("acc_xor", acc_q, 8'h0F);
    mode = 2;
    idle(0);
    send(0, 8'hAA, 8'h55, 0, 0);
    op = 1; a = 8'h11; b = 8'h22; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_y", y, 8'h00);
      chk("stall_zero", zero, 1);
    end
    mode = 0;
    @(posedge clk); #1;
    send(1, 8'h11, 8'h22, 0, 0);
    send(1, 8'hFF, 8'h00, 1, 0);
    idle(0);
    chk("acc_ff", acc_q, 8'hFF);
    send(1, 8'h03, 8'h00, 1, 1);
    idle(0);
    chk("acc_clr_beat", acc_q, 8'h03);
    idle(1);
    idle(0);
    chk("acc_clr_alone", acc_q, INIT);
    mode = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 5) == 0);
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end
    mode = 0;
    repeat (3) idle(0);
    chk("drained", exp_q.size(), 0);
    mode = 2;
    idle(0);
    idle(0);
    send(1, 8'h5A, 8'h00, 1, 0);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_txn_cnt", txn_cnt, 0);
    chk("async_acc_q", acc_q, INIT);
    exp_q.delete();
    macc = INIT;
    mcnt = 0;
    mode = 0;
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    send(7, 8'h0F, 8'h0F, 0, 0);
    send(5, 8'h00, 8'hFF, 0, 0);
    repeat (2) idle(0);
    chk("post_rst_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
